// File: rtl/tetris_pkg.sv
// Shared board geometry and cell addressing for the tetris datapath.
// Used by piece locking, collision detection and line clearing.
package tetris_pkg;

  localparam int BOARD_W  = 10;
  localparam int BOARD_H  = 20;
  localparam int ADDR_W   = 8;
  localparam int COLOUR_W = 6;
  localparam int X_W      = 4;
  localparam int Y_W      = 5;
  localparam int CNT_W    = 5;

  localparam logic [COLOUR_W-1:0] EMPTY_COLOUR = '0;

  function automatic logic [ADDR_W-1:0] cell_addr(
    input logic [X_W-1:0] x,
    input logic [Y_W-1:0] y
  );
    return ADDR_W'(y) * ADDR_W'(BOARD_W) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/line_clear.sv
// Finds full rows bottom-up, drops everything above each one by a row
// and blanks the top row; reports how many rows went per pass.
module line_clear
  import tetris_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [COLOUR_W-1:0] ram_q,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wren,
  output logic [COLOUR_W-1:0] ram_data,
  output logic [CNT_W-1:0]    lines_cleared,
  output logic                board_changed,
  output logic                complete
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN_RD,
    S_SCAN_CHK,
    S_SHIFT_RD,
    S_SHIFT_WR,
    S_CLEAR_TOP,
    S_DONE
  } state_t;

  localparam logic [X_W-1:0] X_LAST = X_W'(BOARD_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(BOARD_H - 1);

  state_t           r_state;
  logic             r_enable_d;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [Y_W-1:0]   r_row;
  logic [CNT_W-1:0] r_cnt;
  logic             w_start;

  assign w_start = enable & ~r_enable_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_enable_d    <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_row         <= '0;
      r_cnt         <= '0;
      ram_addr      <= '0;
      ram_wren      <= 1'b0;
      ram_data      <= '0;
      lines_cleared <= '0;
      board_changed <= 1'b0;
      complete      <= 1'b0;
    end else begin
      r_enable_d <= enable;
      complete   <= 1'b0;
      // Losing enable mid-pass abandons it; the board may be half shifted.
      if (r_state != S_IDLE && !enable) begin
        r_state  <= S_IDLE;
        ram_wren <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_y     <= Y_LAST;
              r_x     <= '0;
              r_cnt   <= '0;
              r_state <= S_SCAN_RD;
            end
          end
          S_SCAN_RD: begin
            ram_addr <= cell_addr(r_x, r_y);
            ram_wren <= 1'b0;
            r_state  <= S_SCAN_CHK;
          end
          S_SCAN_CHK: begin
            if (ram_q == EMPTY_COLOUR) begin
              if (r_y == '0) begin
                r_state <= S_DONE;
              end else begin
                r_y     <= r_y - 1'b1;
                r_x     <= '0;
                r_state <= S_SCAN_RD;
              end
            end else if (r_x == X_LAST) begin
              r_cnt   <= r_cnt + 1'b1;
              r_row   <= r_y;
              r_x     <= '0;
              r_state <= (r_y == '0) ? S_CLEAR_TOP : S_SHIFT_RD;
            end else begin
              r_x     <= r_x + 1'b1;
              r_state <= S_SCAN_RD;
            end
          end
          S_SHIFT_RD: begin
            ram_addr <= cell_addr(r_x, r_row - 1'b1);
            ram_wren <= 1'b0;
            r_state  <= S_SHIFT_WR;
          end
          S_SHIFT_WR: begin
            ram_addr <= cell_addr(r_x, r_row);
            ram_data <= ram_q;
            ram_wren <= 1'b1;
            if (r_x != X_LAST) begin
              r_x     <= r_x + 1'b1;
              r_state <= S_SHIFT_RD;
            end else begin
              r_x     <= '0;
              r_row   <= r_row - 1'b1;
              r_state <= (r_row == Y_W'(1)) ? S_CLEAR_TOP : S_SHIFT_RD;
            end
          end
          S_CLEAR_TOP: begin
            ram_addr <= cell_addr(r_x, '0);
            ram_data <= EMPTY_COLOUR;
            ram_wren <= 1'b1;
            if (r_x == X_LAST) begin
              // A new row dropped into r_y, so it gets rescanned.
              r_x     <= '0;
              r_state <= S_SCAN_RD;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
          S_DONE: begin
            complete      <= 1'b1;
            lines_cleared <= r_cnt;
            board_changed <= (r_cnt != '0);
            r_state       <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_clear.sv
// Bench for line_clear: behavioural RAM, row-compaction board model
// and a row-level latency model, directed plus random boards.
module tb_line_clear;
  import tetris_pkg::*;

  localparam int N = BOARD_W * BOARD_H;
  localparam int TMO = 20000;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                enable = 1'b0;
  logic [COLOUR_W-1:0] ram_q;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_wren;
  logic [COLOUR_W-1:0] ram_data;
  logic [4:0]          lines_cleared;
  logic                board_changed;
  logic                complete;

  always #5 clk = ~clk;

  line_clear dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .ram_q(ram_q),
    .ram_addr(ram_addr),
    .ram_wren(ram_wren),
    .ram_data(ram_data),
    .lines_cleared(lines_cleared),
    .board_changed(board_changed),
    .complete(complete)
  );

  logic [COLOUR_W-1:0] mem [0:N-1];
  logic [COLOUR_W-1:0] init_mem [0:N-1];
  logic [COLOUR_W-1:0] exp_mem [0:N-1];
  logic load_req = 1'b0;
  int wr_cnt = 0;
  int hi_wr_cnt = 0;
  int cmp_cnt = 0;
  int nvec = 0;
  int nfail = 0;
  int exp_lines;
  int exp_lat;

  assign ram_q = (int'(ram_addr) < N) ? mem[ram_addr] : '0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
    end else if (ram_wren && int'(ram_addr) < N) begin
      mem[ram_addr] <= ram_data;
    end
    if (ram_wren) begin
      wr_cnt <= wr_cnt + 1;
      if (int'(ram_addr) >= BOARD_W) hi_wr_cnt <= hi_wr_cnt + 1;
    end
    if (complete) cmp_cnt <= cmp_cnt + 1;
  end

  task automatic clear_init();
    for (int i = 0; i < N; i++) init_mem[i] = '0;
  endtask

  task automatic load_board();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
  endtask

  // Final board: surviving rows keep their order and sink to the bottom.
  // Latency: walk rows bottom-up counting cycles per the scan/shift rules.
  task automatic model_pass();
    logic [COLOUR_W-1:0] b [0:N-1];
    int dst, k, y;
    bit full;
    exp_lines = 0;
    for (int i = 0; i < N; i++) exp_mem[i] = '0;
    dst = BOARD_H - 1;
    for (int yy = BOARD_H - 1; yy >= 0; yy--) begin
      full = 1'b1;
      for (int x = 0; x < BOARD_W; x++)
        if (init_mem[yy*BOARD_W+x] == 0) full = 1'b0;
      if (full) begin
        exp_lines++;
      end else begin
        for (int x = 0; x < BOARD_W; x++)
          exp_mem[dst*BOARD_W+x] = init_mem[yy*BOARD_W+x];
        dst--;
      end
    end
    for (int i = 0; i < N; i++) b[i] = init_mem[i];
    exp_lat = 0;
    y = BOARD_H - 1;
    forever begin
      k = 0;
      while (k < BOARD_W && b[y*BOARD_W+k] != 0) k++;
      if (k == BOARD_W) begin
        exp_lat += 3*BOARD_W + 2*BOARD_W*y;
        for (int yy = y; yy > 0; yy--)
          for (int x = 0; x < BOARD_W; x++)
            b[yy*BOARD_W+x] = b[(yy-1)*BOARD_W+x];
        for (int x = 0; x < BOARD_W; x++) b[x] = '0;
      end else begin
        exp_lat += 2*(k+1);
        if (y == 0) break;
        y--;
      end
    end
    exp_lat += 1;
  endtask

  task automatic run_pass(input bit keep, output int cyc, output bit held);
    bit got;
    logic [4:0] prev;
    prev = lines_cleared;
    held = 1'b1;
    got = 1'b0;
    @(negedge clk) enable = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (!got && cyc < TMO) begin
      @(posedge clk);
      #1;
      cyc++;
      if (complete) got = 1'b1;
      else if (lines_cleared !== prev) held = 1'b0;
    end
    if (!got) cyc = -1;
    if (!keep) begin
      @(negedge clk) enable = 1'b0;
      @(posedge clk);
    end
  endtask

  function automatic int board_diffs(output int first);
    int d;
    d = 0;
    first = -1;
    for (int i = 0; i < N; i++)
      if (mem[i] !== exp_mem[i]) begin
        if (first < 0) first = i;
        d++;
      end
    return d;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (ram_addr !== '0) begin
      nfail++; $display("FAIL reset_addr: got %0d want 0", ram_addr);
    end
    nvec++;
    if (ram_wren !== 1'b0) begin
      nfail++; $display("FAIL reset_wren: got %b want 0", ram_wren);
    end
    nvec++;
    if (ram_data !== '0) begin
      nfail++; $display("FAIL reset_data: got %0h want 0", ram_data);
    end
    nvec++;
    if (lines_cleared !== 5'd0) begin
      nfail++; $display("FAIL reset_lines: got %0d want 0", lines_cleared);
    end
    nvec++;
    if (board_changed !== 1'b0 || complete !== 1'b0) begin
      nfail++;
      $display("FAIL reset_flags: got chg=%b cmp=%b want 0 0",
               board_changed, complete);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_pass(input string nm, input int cyc);
    int d, f;
    d = board_diffs(f);
    nvec++;
    if (d !== 0) begin
      nfail++;
      $display("FAIL %s board: %0d cells differ, first addr %0d got %0h want %0h",
               nm, d, f, mem[f], exp_mem[f]);
    end
    nvec++;
    if (int'(lines_cleared) !== exp_lines) begin
      nfail++;
      $display("FAIL %s lines: got %0d want %0d", nm, lines_cleared, exp_lines);
    end
    nvec++;
    if (board_changed !== (exp_lines != 0)) begin
      nfail++;
      $display("FAIL %s changed: got %b want %b", nm, board_changed, exp_lines != 0);
    end
    nvec++;
    if (cyc !== exp_lat) begin
      nfail++;
      $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_lat);
    end
  endtask

  task automatic test_empty();
    int cyc, w0;
    bit held;
    clear_init();
    load_board();
    model_pass();
    w0 = wr_cnt;
    run_pass(1'b0, cyc, held);
    check_pass("empty", cyc);
    nvec++;
    if (cyc !== 2*BOARD_H + 1) begin
      nfail++; $display("FAIL empty_41: got %0d want %0d", cyc, 2*BOARD_H + 1);
    end
    nvec++;
    if (wr_cnt - w0 !== 0) begin
      nfail++; $display("FAIL empty_nowr: got %0d writes want 0", wr_cnt - w0);
    end
  endtask

  task automatic test_single();
    int cyc;
    bit held;
    clear_init();
    for (int x = 0; x < BOARD_W; x++) init_mem[19*BOARD_W+x] = 6'h05;
    for (int x = 0; x < 5; x++) init_mem[18*BOARD_W+x] = 6'h0A;
    load_board();
    model_pass();
    run_pass(1'b0, cyc, held);
    check_pass("single", cyc);
    nvec++;
    if (mem[19*BOARD_W+4] !== 6'h0A || mem[19*BOARD_W+5] !== 6'h00) begin
      nfail++;
      $display("FAIL single_row19: got %0h %0h want a 0",
               mem[19*BOARD_W+4], mem[19*BOARD_W+5]);
    end
  endtask

  task automatic test_quad(input bit keep);
    int cyc;
    bit held;
    clear_init();
    for (int y = 16; y < 20; y++)
      for (int x = 0; x < BOARD_W; x++)
        init_mem[y*BOARD_W+x] = COLOUR_W'(y + 1);
    init_mem[15*BOARD_W+3] = 6'h11;
    load_board();
    model_pass();
    run_pass(keep, cyc, held);
    check_pass("quad", cyc);
    nvec++;
    if (mem[19*BOARD_W+3] !== 6'h11) begin
      nfail++; $display("FAIL quad_cell: got %0h want 11", mem[19*BOARD_W+3]);
    end
  endtask

  task automatic test_top_row();
    int cyc, w0, h0;
    bit held;
    clear_init();
    for (int x = 0; x < BOARD_W; x++) init_mem[x] = 6'h3F;
    load_board();
    model_pass();
    w0 = wr_cnt;
    h0 = hi_wr_cnt;
    run_pass(1'b0, cyc, held);
    check_pass("toprow", cyc);
    nvec++;
    if (hi_wr_cnt - h0 !== 0 || wr_cnt - w0 !== BOARD_W) begin
      nfail++;
      $display("FAIL toprow_noshift: got %0d low/%0d high writes want %0d/0",
               wr_cnt - w0 - (hi_wr_cnt - h0), hi_wr_cnt - h0, BOARD_W);
    end
  endtask

  task automatic test_hold_restart();
    int cyc, w0, c0;
    bit held;
    test_quad(1'b1);
    clear_init();
    for (int x = 0; x < BOARD_W; x++) init_mem[19*BOARD_W+x] = 6'h07;
    init_mem[17*BOARD_W+6] = 6'h21;
    load_board();
    w0 = wr_cnt;
    c0 = cmp_cnt;
    repeat (60) @(posedge clk);
    #1;
    nvec++;
    if (wr_cnt - w0 !== 0 || cmp_cnt - c0 !== 0) begin
      nfail++;
      $display("FAIL hold_norestart: got %0d writes %0d completes want 0 0",
               wr_cnt - w0, cmp_cnt - c0);
    end
    @(negedge clk) enable = 1'b0;
    @(posedge clk);
    model_pass();
    run_pass(1'b0, cyc, held);
    nvec++;
    if (held !== 1'b1) begin
      nfail++; $display("FAIL hold_lines: got early change want held at 4");
    end
    check_pass("restart", cyc);
  endtask

  task automatic test_reset_mid();
    int n, w0, c0;
    clear_init();
    for (int x = 0; x < BOARD_W; x++) init_mem[19*BOARD_W+x] = 6'h15;
    for (int x = 0; x < BOARD_W; x++) init_mem[18*BOARD_W+x] = (x < 3) ? 6'h2A : 6'h00;
    load_board();
    @(negedge clk) enable = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (ram_wren !== 1'b1 && n < TMO);
    nvec++;
    if (ram_wren !== 1'b1 || ram_data !== 6'h2A) begin
      nfail++;
      $display("FAIL rstmid_reach: got wren=%b data=%0h want 1 2a", ram_wren, ram_data);
    end
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if (ram_wren !== 1'b0 || complete !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_ctl: got wren=%b cmp=%b want 0 0", ram_wren, complete);
    end
    nvec++;
    if (ram_addr !== '0 || ram_data !== '0) begin
      nfail++;
      $display("FAIL rstmid_bus: got addr=%0d data=%0h want 0 0", ram_addr, ram_data);
    end
    nvec++;
    if (lines_cleared !== 5'd0 || board_changed !== 1'b0) begin
      nfail++;
      $display("FAIL rstmid_stat: got lines=%0d chg=%b want 0 0",
               lines_cleared, board_changed);
    end
    enable = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    w0 = wr_cnt;
    c0 = cmp_cnt;
    repeat (6) @(posedge clk);
    #1;
    nvec++;
    if (wr_cnt - w0 !== 0 || cmp_cnt - c0 !== 0) begin
      nfail++;
      $display("FAIL rstmid_idle: got %0d writes %0d completes want 0 0",
               wr_cnt - w0, cmp_cnt - c0);
    end
  endtask

  task automatic test_random();
    int cyc, m, hole;
    bit held;
    for (int t = 0; t < 12; t++) begin
      clear_init();
      for (int y = 0; y < BOARD_H; y++) begin
        m = $urandom_range(0, 3);
        hole = $urandom_range(0, BOARD_W - 1);
        for (int x = 0; x < BOARD_W; x++) begin
          case (m)
            1: init_mem[y*BOARD_W+x] = COLOUR_W'($urandom_range(1, 63));
            2: init_mem[y*BOARD_W+x] = ($urandom_range(0, 9) < 7) ?
                 COLOUR_W'($urandom_range(1, 63)) : '0;
            3: init_mem[y*BOARD_W+x] = (x == hole) ? '0 :
                 COLOUR_W'($urandom_range(1, 63));
            default: init_mem[y*BOARD_W+x] = '0;
          endcase
        end
      end
      load_board();
      model_pass();
      run_pass(1'b0, cyc, held);
      check_pass($sformatf("rand%0d", t), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_single();
    test_quad(1'b0);
    test_top_row();
    test_hold_restart();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
